// File: rtl/seq_trigger3.sv
`default_nettype none
// ============================================================================
// Module   : seq_trigger3
// Purpose  : Detects "load_mem ##1 done" (ready) and "load_mem ##[1:MAX_DLY] done" (ready2).
//            Optional saturating trigger counter is enabled with SEQ_TRIGGER3_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seq_trigger3 #(
    parameter int MAX_DLY = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_mem,
    input  logic             done,
    output logic             ready,
    output logic             ready2
`ifdef SEQ_TRIGGER3_CNT_EN
    ,
    output logic [CNT_W-1:0] trig_cnt
`endif
);

    // hist_q[k-1] is set when load_mem was sampled high k clocks ago
    logic [MAX_DLY-1:0] hist_q;
    logic [MAX_DLY-1:0] hist_d;
    logic               ready2_q;
    logic               ready2_d;

    always_comb begin
        hist_d    = hist_q;
        hist_d[0] = load_mem;
        for (int i = 1; i < MAX_DLY; i++) begin
            hist_d[i] = hist_q[i-1];
        end
        ready2_d = done & (|hist_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q   <= '0;
            ready2_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            ready2_q <= ready2_d;
        end
    end

    assign ready  = done & hist_q[0];
    assign ready2 = ready2_q;

`ifdef SEQ_TRIGGER3_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign trig_cnt = cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_trigger3.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_trigger3
// Purpose  : Randomized and directed self-checking bench for seq_trigger3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_trigger3;

    logic clk = 1'b0;
    logic reset;
    logic load_mem;
    logic done;
    logic ready_a, ready2_a;
    logic ready_b, ready2_b;
`ifdef SEQ_TRIGGER3_CNT_EN
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
`endif

    always #5 clk = ~clk;

    seq_trigger3 #(.MAX_DLY(4), .CNT_W(8)) u_dut4 (
        .clk      (clk),
        .reset    (reset),
        .load_mem (load_mem),
        .done     (done),
        .ready    (ready_a),
        .ready2   (ready2_a)
`ifdef SEQ_TRIGGER3_CNT_EN
        ,
        .trig_cnt (cnt_a)
`endif
    );

    seq_trigger3 #(.MAX_DLY(5), .CNT_W(2)) u_dut5 (
        .clk      (clk),
        .reset    (reset),
        .load_mem (load_mem),
        .done     (done),
        .ready    (ready_b),
        .ready2   (ready2_b)
`ifdef SEQ_TRIGGER3_CNT_EN
        ,
        .trig_cnt (cnt_b)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: list of posedge indices at which load_mem was sampled high
    int cyc = 0;
    int lq[$];
    int exp_cnt_a = 0;
    int exp_cnt_b = 0;

    logic obs_rdy_a, obs_rdy_b, obs_r2_a, obs_r2_b;
    logic exp_rdy, exp_r2_4, exp_r2_5;

    function automatic bit load_in(input int lo, input int hi);
        foreach (lq[i]) if (lq[i] >= lo && lq[i] <= hi) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_clear();
        lq.delete();
        exp_cnt_a = 0;
        exp_cnt_b = 0;
    endfunction

    // Drives one clock of stimulus and records observed/expected values.
    task automatic step(input bit lm, input bit dn);
        @(negedge clk);
        load_mem = lm;
        done     = dn;
        #2;
        obs_rdy_a = ready_a;
        obs_rdy_b = ready_b;
        exp_rdy   = dn && load_in(cyc, cyc);
        @(posedge clk);
        cyc++;
        exp_r2_4 = dn && load_in(cyc - 4, cyc - 1);
        exp_r2_5 = dn && load_in(cyc - 5, cyc - 1);
        if (exp_rdy) begin
            exp_cnt_a = (exp_cnt_a < 255) ? exp_cnt_a + 1 : 255;
            exp_cnt_b = (exp_cnt_b < 3) ? exp_cnt_b + 1 : 3;
        end
        if (lm) lq.push_back(cyc);
        while (lq.size() > 0 && lq[0] < cyc - 20) void'(lq.pop_front());
        #1;
        obs_r2_a = ready2_a;
        obs_r2_b = ready2_b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        n_chk++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b/%b expected 0/0", ready_a, ready_b);
        end
        n_chk++;
        if (ready2_a !== 1'b0 || ready2_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready2: got %b/%b expected 0/0", ready2_a, ready2_b);
        end
`ifdef SEQ_TRIGGER3_CNT_EN
        n_chk++;
        if (cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt_a, cnt_b);
        end
`endif
    endtask

    task automatic test_single_match();
        idle(6);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        n_chk++;
        if (obs_rdy_a !== 1'b1 || obs_rdy_b !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b/%b expected 1/1", obs_rdy_a, obs_rdy_b);
        end
        n_chk++;
        if (obs_r2_a !== 1'b1 || obs_r2_b !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready2: got %b/%b expected 1/1", obs_r2_a, obs_r2_b);
        end
        step(1'b0, 1'b0);
        n_chk++;
        if (obs_rdy_a !== 1'b0 || obs_r2_a !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: got %b/%b expected 0/0", obs_rdy_a, obs_r2_a);
        end
    endtask

    // done held high after one load: ready2 high for MAX_DLY cycles, then drops
    task automatic test_done_hold();
        idle(6);
        step(1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            step(1'b0, 1'b1);
            n_chk++;
            if (obs_rdy_a !== ((k == 1) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL hold_ready[%0d]: got %b expected %b", k, obs_rdy_a, (k == 1));
            end
            n_chk++;
            if (obs_r2_a !== ((k <= 4) ? 1'b1 : 1'b0) || obs_r2_b !== ((k <= 5) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL hold_ready2[%0d]: got %b/%b expected %b/%b",
                         k, obs_r2_a, obs_r2_b, (k <= 4), (k <= 5));
            end
        end
    endtask

    task automatic test_overlap();
        idle(6);
        step(1'b1, 1'b1);
        n_chk++;
        if (obs_rdy_a !== 1'b0 || obs_r2_a !== 1'b0 || obs_r2_b !== 1'b0) begin
            n_fail++;
            $display("FAIL overlap_same: got %b/%b/%b expected 0/0/0", obs_rdy_a, obs_r2_a, obs_r2_b);
        end
        step(1'b0, 1'b0);
        n_chk++;
        if (obs_rdy_a !== 1'b0 || obs_r2_a !== 1'b0) begin
            n_fail++;
            $display("FAIL overlap_after: got %b/%b expected 0/0", obs_rdy_a, obs_r2_a);
        end
        // the overlapping load still counts for a later done
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        n_chk++;
        if (obs_rdy_a !== 1'b1 || obs_r2_a !== 1'b1) begin
            n_fail++;
            $display("FAIL overlap_later: got %b/%b expected 1/1", obs_rdy_a, obs_r2_a);
        end
    endtask

    task automatic test_late_done();
        idle(7);
        step(1'b1, 1'b0);
        idle(4);
        step(1'b0, 1'b1);
        n_chk++;
        if (obs_rdy_a !== 1'b0 || obs_r2_a !== 1'b0) begin
            n_fail++;
            $display("FAIL late_d4: got %b/%b expected 0/0", obs_rdy_a, obs_r2_a);
        end
        n_chk++;
        if (obs_r2_b !== 1'b1) begin
            n_fail++;
            $display("FAIL late_d5: got %b expected 1", obs_r2_b);
        end
        step(1'b0, 1'b0);
        n_chk++;
        if (obs_r2_b !== 1'b0) begin
            n_fail++;
            $display("FAIL late_d5_drop: got %b expected 0", obs_r2_b);
        end
    endtask

    task automatic test_back_to_back();
        idle(7);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        n_chk++;
        if (obs_rdy_a !== 1'b1 || obs_r2_a !== 1'b1 || obs_r2_b !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_match: got %b/%b/%b expected 1/1/1", obs_rdy_a, obs_r2_a, obs_r2_b);
        end
        step(1'b0, 1'b0);
        n_chk++;
        if (obs_r2_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_single: got %b expected 0", obs_r2_a);
        end
    endtask

    task automatic test_reset_mid();
        idle(6);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        @(negedge clk);
        load_mem = 1'b0;
        done     = 1'b1;
        #2;
        n_chk++;
        if (ready_a !== 1'b1 || ready2_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got %b/%b expected 1/1", ready_a, ready2_a);
        end
        reset = 1'b1;
        #1;
        model_clear();
        n_chk++;
        if (ready_a !== 1'b0 || ready2_a !== 1'b0 || ready_b !== 1'b0 || ready2_b !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %b/%b/%b/%b expected 0/0/0/0",
                     ready_a, ready2_a, ready_b, ready2_b);
        end
`ifdef SEQ_TRIGGER3_CNT_EN
        n_chk++;
        if (cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_cnt: got %0d/%0d expected 0/0", cnt_a, cnt_b);
        end
`endif
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b1);
        n_chk++;
        if (obs_rdy_a !== 1'b0 || obs_r2_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_nomatch: got %b/%b expected 0/0", obs_rdy_a, obs_r2_a);
        end
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        n_chk++;
        if (obs_rdy_a !== 1'b1 || obs_r2_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_rematch: got %b/%b expected 1/1", obs_rdy_a, obs_r2_a);
        end
    endtask

`ifdef SEQ_TRIGGER3_CNT_EN
    task automatic test_counter_sat();
        int base_b;
        base_b = exp_cnt_b;
        for (int k = 1; k <= 5; k++) begin
            idle(2);
            step(1'b1, 1'b0);
            step(1'b0, 1'b1);
            n_chk++;
            if (int'(cnt_b) != ((base_b + k > 3) ? 3 : base_b + k)) begin
                n_fail++;
                $display("FAIL cnt_sat[%0d]: got %0d expected %0d", k, cnt_b,
                         (base_b + k > 3) ? 3 : base_b + k);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1);
            n_chk++;
            if (obs_rdy_a !== exp_rdy || obs_rdy_b !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b/%b expected %b", k, obs_rdy_a, obs_rdy_b, exp_rdy);
            end
            n_chk++;
            if (obs_r2_a !== exp_r2_4 || obs_r2_b !== exp_r2_5) begin
                n_fail++;
                $display("FAIL rand_ready2[%0d]: got %b/%b expected %b/%b",
                         k, obs_r2_a, obs_r2_b, exp_r2_4, exp_r2_5);
            end
`ifdef SEQ_TRIGGER3_CNT_EN
            n_chk++;
            if (int'(cnt_a) != exp_cnt_a || int'(cnt_b) != exp_cnt_b) begin
                n_fail++;
                $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d",
                         k, cnt_a, cnt_b, exp_cnt_a, exp_cnt_b);
            end
`endif
        end
    endtask

    initial begin
        reset    = 1'b1;
        load_mem = 1'b0;
        done     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        test_reset();
        test_single_match();
        test_done_hold();
        test_overlap();
        test_late_done();
        test_back_to_back();
        test_reset_mid();
`ifdef SEQ_TRIGGER3_CNT_EN
        test_counter_sat();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_trigger3.md
Name: seq_trigger3

Overview:
- Sequence-endpoint detector for a memory-load handshake.
- Watches for `load_mem` followed by `done` and raises two flags:
  - `ready`: combinational endpoint flag, asserted in the cycle the sequence "load_mem ##1 done" completes (a triggered-style endpoint).
  - `ready2`: registered flag for the relaxed sequence "load_mem ##[1:MAX_DLY] done".
- Sits beside a memory-load controller as a status/monitor block.

Parameters:
- MAX_DLY, 4, maximum delay in clocks from `load_mem` to `done` accepted by `ready2`; legal range 1..16.
- CNT_W, 8, width of the optional trigger counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous active-high reset.
- load_mem  input  1  memory load strobe, sampled on posedge clk.
- done  input  1  load-complete indication, sampled on posedge clk and also used combinationally.
- ready  output  1  combinational; high while `done` is high and `load_mem` was sampled high at the previous posedge.
- ready2  output  1  registered; high for one cycle after each posedge at which the relaxed sequence completed.
- trig_cnt  output  CNT_W  only when SEQ_TRIGGER3_CNT_EN is defined; see Optional Feature.

Behaviour:
- History register `hist[MAX_DLY-1:0]`:
  - At each posedge: `hist[0]` <= `load_mem`, `hist[i]` <= `hist[i-1]`.
  - `hist[k-1]` therefore means "`load_mem` was sampled high k clocks ago".
- `ready` = `done` & `hist[0]`:
  - Purely combinational, no added latency.
  - Follows `done` within the cycle.
  - X on `done` while `hist[0]`=0 yields 0; `hist[0]` is never X after reset.
- `ready2`:
  - At posedge, `ready2` <= `done` & (OR of `hist[MAX_DLY-1:0]`), using pre-update `hist` values.
  - Latency: one clock after the completing posedge.
  - Stays high on consecutive cycles while the condition holds.
- Overlap: `load_mem` and `done` both high at the same posedge do not match (zero delay excluded). That `load_mem` still enters `hist` and can match a later `done`.
- Back-to-back `load_mem` pulses each start an independent attempt. A single `done` satisfying several attempts produces one assertion, not several.
- `done` more than MAX_DLY clocks after `load_mem`: `ready2` stays 0, `ready` stays 0.
- `done` held high continuously: `ready2` stays high as long as some `load_mem` lies within the window, then drops MAX_DLY+1 clocks after the last `load_mem`.
- Reset (asynchronous, any time including mid-sequence):
  - `hist` cleared to 0, `ready2`=0, `trig_cnt`=0; `ready` therefore 0.
  - Pending attempts are discarded.
  - First match is possible at the second posedge after reset release (the one after `load_mem` is first sampled).
- X/undriven inputs before the first drive are not checked; outputs are only required valid once inputs are known.

Optional Feature:
- Macro SEQ_TRIGGER3_CNT_EN.
- Defined:
  - Port `trig_cnt` [CNT_W-1:0] exists.
  - Increments by 1 at each posedge where `ready` is high, i.e. `done` & `hist[0]` sampled.
  - Saturates at all-ones (no wrap).
  - Cleared by reset.
- Undefined:
  - Port and counter logic are absent.
  - `ready`/`ready2` behaviour is identical in both builds.

Test Plan:
- Reset asserted mid-run with `hist` non-zero -> `ready`=0 and `ready2`=0 immediately (asynchronous), `trig_cnt`=0; no match until a new `load_mem` is sampled.
- `load_mem`=1 at posedge n, then `load_mem`=0 and `done`=1 from before posedge n+1 -> `ready`=1 throughout cycle n+1; `ready2`=1 after posedge n+1.
- Same stimulus with `done` held high afterward, MAX_DLY=4 -> `ready` drops after posedge n+1; `ready2` high after posedges n+1..n+4 and low after posedge n+5.
- `load_mem` and `done` both 1 at posedge n only, then both 0 -> `ready` stays 0, `ready2` stays 0.
- `done` arrives 5 clocks after a single `load_mem` with MAX_DLY=4 -> `ready`=0, `ready2`=0; with MAX_DLY=5 -> `ready2`=1 for one cycle.
- SEQ_TRIGGER3_CNT_EN, CNT_W=2, five separate `load_mem`→`done` pairs -> `trig_cnt` reads 1, 2, 3, 3, 3 (saturates).
